ifmap_ring_buffer: RTL and testbench
====================================

# ifmap_ring_buffer

N-bank rotating successor to the two-bank ping-pong ifmap buffer, sitting between the AXI-stream DMA and the img2col/GEMM core. At any time one bank is filled by the DMA, one serves the compute core (tensor reads plus result writes), and one is drained back to the DMA. Banks rotate roles on each accepted `conv_en`, so ifmap load, compute and result read-out fully overlap. Data width, depth and bank count are parameters.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 10, per-bank address width; depth 2^ADDR_WIDTH
- NUM_BANKS, 3, bank count; legal range 3..8
- BW, $clog2(NUM_BANKS), bank index width (localparam)
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- enable  in  1  gates acceptance of `conv_en`/`flush`
- conv_en  in  1  single-cycle pulse; requests rotation
- flush  in  1  single-cycle pulse; drains current compute bank without rotation
- n_ifmap_num  in  ADDR_WIDTH+1  expected DMA input beats (length-check only)
- n_ofmap_num  in  ADDR_WIDTH+1  result words to drain; sampled at drain start
- w_data  in  DATA_WIDTH  DMA write data
- w_valid  in  1  DMA write valid
- w_last  in  1  last DMA write beat
- w_ready  out  1  write ready
- r_data  out  DATA_WIDTH  drain data
- r_valid  out  1  drain valid
- r_last  out  1  final drain beat
- r_ready  in  1  drain ready
- tensor_addr  in  ADDR_WIDTH  compute read address
- t_addr_vld  in  1  compute read strobe
- tensor_data  out  DATA_WIDTH  compute read data
- tensor_vld  out  1  `tensor_data` valid
- result_addr  in  ADDR_WIDTH  result write address
- result_data  in  DATA_WIDTH  result write data
- result_w_vld  in  1  result write strobe
- comp_bank  out  BW  bank currently in compute role
- drain_busy  out  1  drain in progress
- conv_err  out  1  single-cycle pulse: `conv_en`/`flush` rejected
- len_err  out  1  sticky length error (see Configuration)

## Operation
- Each bank is a simple dual-port RAM (1 write port, 1 read port, 1-cycle read latency). Roles: compute = `cptr`, fill = `cptr+1`, drain = `cptr-1`, all mod NUM_BANKS. Distinct roles never share a port.
- Write port mux: fill bank takes DMA writes, compute bank takes result writes. Read port mux: compute bank serves `tensor_addr`, drain bank serves the drain counter.
- Fill: `w_ready`=1 while `loaded[fill]`=0. Each handshake writes `w_addr` and increments it. A handshake with `w_last` sets `loaded[fill]`, clears `w_addr`, drops `w_ready`.
- `conv_en` is accepted when `enable`, `loaded[fill]`, and `!drain_busy`. On acceptance: `cptr` advances; the new fill bank gets `loaded` cleared and `w_ready` rises the next cycle; if `comp_valid`, drain of old compute bank starts; `comp_valid` is set. Otherwise `conv_err` pulses and nothing changes.
- `flush` is accepted when `enable`, `comp_valid`, and `!drain_busy`. It drains the compute bank and clears `comp_valid`. Otherwise `conv_err` pulses. If `conv_en` and `flush` arrive in the same cycle, `conv_en` wins and `flush` is ignored without error.
- Drain: reads addresses 0..n_ofmap_num-1 into a 2-entry output FIFO. A read issues only when FIFO occupancy plus in-flight reads is less than 2. `r_last` accompanies word n_ofmap_num-1. `drain_busy` clears after the `r_last` handshake. If n_ofmap_num=0, the drain is skipped.

## Timing
- Reset values: `w_ready`=0 for 1 cycle, then 1 (bank 1 empty). `r_valid`, `r_last`, `tensor_vld`, `conv_err`, `len_err`, `drain_busy` = 0. `r_data`, `tensor_data` = 0. `comp_bank`=0, `comp_valid`=0, all `loaded`=0. RAM contents are not cleared.
- `tensor_data`/`tensor_vld` are registered 1 cycle after `t_addr_vld`. Result writes land on the same edge.
- First `r_valid` comes 2 cycles after drain acceptance. Throughput is 1 beat/cycle while `r_ready`=1. `r_data`/`r_last` hold stable while `r_valid && !r_ready`.
- `conv_en` evaluates registered `loaded`. A `w_last` handshake in the same cycle as `conv_en` therefore gets a rejection.
- Reset mid-transfer aborts everything immediately and returns all outputs to their reset values.
- Address counters are ADDR_WIDTH+1 bits. A DMA write past 2^ADDR_WIDTH beats wraps to 0.

## Configuration
- `IFMAP_RING_LEN_CHECK_EN` defined: the DMA beat count is compared with the `n_ifmap_num` value sampled at fill start.
  - `w_last` early or late sets `len_err` (sticky until reset).
  - Beats beyond `n_ifmap_num` are accepted but not written.
  - The bank is marked loaded only on `w_last`.
- Undefined: no check, `len_err` tied 0, every accepted beat is written.

## Test plan
- Reset, load 16 words 0..15 into bank 1, `conv_en` -> `comp_bank`=1, no drain, `t_addr_vld` at addr 5 -> `tensor_data`=5 one cycle later.
- Results 100+i written to bank 1, bank 2 loaded, `conv_en` with n_ofmap_num=8 -> drain of bank 1 emits 100..107, `r_last` on 107, `comp_bank`=2.
- Drain with `r_ready` toggling 1/0 every cycle -> no lost or duplicated words, `r_data` stable during stalls.
- `conv_en` while fill bank not loaded, or while `drain_busy` -> `conv_err` one-cycle pulse, `comp_bank` unchanged.
- Rotate 4 times with NUM_BANKS=4 -> `comp_bank` sequence 1,2,3,0, then `flush` drains bank 0 and clears `comp_valid`.
- With macro: n_ifmap_num=8, `w_last` on beat 6 -> `len_err`=1. Without macro: `len_err` stays 0.

Source files
------------

// File: rtl/ifmap_ring_buffer.sv
// ifmap_ring_buffer: N-bank rotating ifmap/result buffer, DMA <-> GEMM core.
// Roles: compute=cptr, fill=cptr+1, drain=cptr-1 (mod NUM_BANKS); rotate on conv_en.
// Optional macro IFMAP_RING_LEN_CHECK_EN: DMA beat count check drives len_err.
// Ports: clk, rstn (async low); enable/conv_en/flush/n_ifmap_num/n_ofmap_num ctrl;
//   w_* DMA fill in; r_* drain out; tensor_*/result_* compute port;
//   comp_bank, drain_busy, conv_err (pulse), len_err (sticky) status.
module ifmap_ring_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BANKS  = 3,
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  conv_en,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   n_ifmap_num,
  input  logic [ADDR_WIDTH:0]   n_ofmap_num,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  input  logic                  w_last,
  output logic                  w_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  r_last,
  input  logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] tensor_addr,
  input  logic                  t_addr_vld,
  output logic [DATA_WIDTH-1:0] tensor_data,
  output logic                  tensor_vld,
  input  logic [ADDR_WIDTH-1:0] result_addr,
  input  logic [DATA_WIDTH-1:0] result_data,
  input  logic                  result_w_vld,
  output logic [BW-1:0]         comp_bank,
  output logic                  drain_busy,
  output logic                  conv_err,
  output logic                  len_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef logic [BW-1:0] bank_t;

  function automatic bank_t bank_inc(bank_t b);
    return (int'(b) == NUM_BANKS - 1) ? '0 : b + bank_t'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

  bank_t                 cptr_q, cptr_d;
  bank_t                 dbank_q, dbank_d;
  logic [NUM_BANKS-1:0]  loaded_q, loaded_d;
  logic                  comp_valid_q, comp_valid_d;
  logic                  rdy_en_q;
  logic [CW-1:0]         w_addr_q, w_addr_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         rd_addr_q, rd_addr_d;
  logic [CW-1:0]         n_q, n_d;
  logic                  infl_q;
  logic                  infl_last_q;
  logic [DATA_WIDTH-1:0] infl_data_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]            fifo_last_q;
  logic                  wp_q, rp_q;
  logic [1:0]            cnt_q;
  logic                  conv_err_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvld_q;

  bank_t      fill_b;
  logic       w_hs, w_we;
  logic       conv_acc, flush_req, flush_acc, reject;
  logic       start, pop, issue, rd_last;
  logic [1:0] occ;

  assign fill_b  = bank_inc(cptr_q);
  assign w_ready = rdy_en_q & ~loaded_q[fill_b];
  assign w_hs    = w_valid & w_ready;

  assign conv_acc  = conv_en & enable & loaded_q[fill_b] & ~busy_q;
  assign flush_req = flush & ~conv_en;
  assign flush_acc = flush_req & enable & comp_valid_q & ~busy_q;
  assign reject    = (conv_en & ~conv_acc) | (flush_req & ~flush_acc);
  assign start     = ((conv_acc & comp_valid_q) | flush_acc)
                   & (n_ofmap_num != '0);

  assign r_valid = (cnt_q != 2'd0);
  assign r_data  = fifo_data_q[rp_q];
  assign r_last  = r_valid & fifo_last_q[rp_q];
  assign pop     = r_valid & r_ready;

  // Occupancy after this edge, counting the read already in flight.
  assign occ     = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue   = busy_q & (rd_addr_q < n_q) & (occ < 2'd2);
  assign rd_last = (rd_addr_q == n_q - CW'(1));

  assign comp_bank   = cptr_q;
  assign drain_busy  = busy_q;
  assign conv_err    = conv_err_q;
  assign tensor_data = tdata_q;
  assign tensor_vld  = tvld_q;

`ifdef IFMAP_RING_LEN_CHECK_EN
  logic [CW-1:0] exp_q, exp_d, exp_n;
  logic          len_err_q, len_err_d;

  // Expected length is latched on the first beat of each fill.
  assign exp_n   = (w_addr_q == '0) ? n_ifmap_num : exp_q;
  assign w_we    = w_hs & (w_addr_q < exp_n);
  assign len_err = len_err_q;

  always_comb begin
    exp_d     = exp_q;
    len_err_d = len_err_q;
    if (w_hs && w_addr_q == '0) exp_d = n_ifmap_num;
    if (w_hs && w_last && (w_addr_q + CW'(1) != exp_n))
      len_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      len_err_q <= len_err_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^n_ifmap_num;
  assign w_we      = w_hs;
  assign len_err   = 1'b0;
`endif

  always_comb begin
    cptr_d       = cptr_q;
    loaded_d     = loaded_q;
    comp_valid_d = comp_valid_q;
    w_addr_d     = w_addr_q;
    busy_d       = busy_q;
    dbank_d      = dbank_q;
    rd_addr_d    = rd_addr_q;
    n_d          = n_q;
    if (w_hs) begin
      if (w_last) begin
        loaded_d[fill_b] = 1'b1;
        w_addr_d         = '0;
      end else begin
        w_addr_d = w_addr_q + CW'(1);
      end
    end
    if (conv_acc) begin
      cptr_d                   = fill_b;
      loaded_d[bank_inc(fill_b)] = 1'b0;
      comp_valid_d             = 1'b1;
    end
    if (flush_acc) comp_valid_d = 1'b0;
    if (issue) rd_addr_d = rd_addr_q + CW'(1);
    if (pop && r_last) busy_d = 1'b0;
    // Both rotation and flush drain the bank that was computing.
    if (start) begin
      busy_d    = 1'b1;
      dbank_d   = cptr_q;
      rd_addr_d = '0;
      n_d       = n_ofmap_num;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cptr_q       <= '0;
      dbank_q      <= '0;
      loaded_q     <= '0;
      comp_valid_q <= 1'b0;
      rdy_en_q     <= 1'b0;
      w_addr_q     <= '0;
      busy_q       <= 1'b0;
      rd_addr_q    <= '0;
      n_q          <= '0;
      conv_err_q   <= 1'b0;
    end else begin
      cptr_q       <= cptr_d;
      dbank_q      <= dbank_d;
      loaded_q     <= loaded_d;
      comp_valid_q <= comp_valid_d;
      rdy_en_q     <= 1'b1;
      w_addr_q     <= w_addr_d;
      busy_q       <= busy_d;
      rd_addr_q    <= rd_addr_d;
      n_q          <= n_d;
      conv_err_q   <= reject;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      mem_q[fill_b][w_addr_q[ADDR_WIDTH-1:0]] <= w_data;
    if (result_w_vld)
      mem_q[cptr_q][result_addr] <= result_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tvld_q  <= 1'b0;
      tdata_q <= '0;
    end else begin
      tvld_q <= t_addr_vld;
      if (t_addr_vld) tdata_q <= mem_q[cptr_q][tensor_addr];
    end
  end

  // Drain pipe: RAM read stage, then a 2-entry output FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_data_q <= '0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        infl_data_q <= mem_q[dbank_q][rd_addr_q[ADDR_WIDTH-1:0]];
        infl_last_q <= rd_last;
      end
      if (infl_q) begin
        fifo_data_q[wp_q] <= infl_data_q;
        fifo_last_q[wp_q] <= infl_last_q;
        wp_q              <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifmap_ring_buffer.sv
// tb_ifmap_ring_buffer: table-driven tensor reads plus drain scoreboard.
// 4 banks, 16-word banks; covers rotation, drain, stalls, errors, reset.
module tb_ifmap_ring_buffer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NB = 4;
`ifdef IFMAP_RING_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable, conv_en, flush;
  logic [AW:0]   n_ifmap_num, n_ofmap_num;
  logic [DW-1:0] w_data;
  logic          w_valid, w_last, w_ready;
  logic [DW-1:0] r_data;
  logic          r_valid, r_last, r_ready;
  logic [AW-1:0] tensor_addr;
  logic          t_addr_vld;
  logic [DW-1:0] tensor_data;
  logic          tensor_vld;
  logic [AW-1:0] result_addr;
  logic [DW-1:0] result_data;
  logic          result_w_vld;
  logic [1:0]    comp_bank;
  logic          drain_busy, conv_err, len_err;

  ifmap_ring_buffer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .conv_en(conv_en), .flush(flush),
    .n_ifmap_num(n_ifmap_num), .n_ofmap_num(n_ofmap_num),
    .w_data(w_data), .w_valid(w_valid), .w_last(w_last),
    .w_ready(w_ready),
    .r_data(r_data), .r_valid(r_valid), .r_last(r_last),
    .r_ready(r_ready),
    .tensor_addr(tensor_addr), .t_addr_vld(t_addr_vld),
    .tensor_data(tensor_data), .tensor_vld(tensor_vld),
    .result_addr(result_addr), .result_data(result_data),
    .result_w_vld(result_w_vld),
    .comp_bank(comp_bank), .drain_busy(drain_busy),
    .conv_err(conv_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } tv_t;
  tv_t tv[9];

  logic [32:0] sb[$];
  bit          hold_v;
  logic [32:0] hold;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("r_stable", 64'({r_valid, r_last, r_data}),
            64'({1'b1, hold}));
      if (r_valid && r_ready) begin
        if (sb.size() == 0) chk("r_unexpected", 64'(sb.size()), 64'(1));
        else chk("r_beat", 64'({r_last, r_data}), 64'(sb.pop_front()));
      end
      hold_v = r_valid && !r_ready;
      hold   = {r_last, r_data};
    end
  end

  task automatic push(int base, int n);
    for (int i = 0; i < n; i++)
      sb.push_back({i == n - 1, 32'(base + i)});
  endtask

  task automatic load(int n, int base, int nif);
    int g;
    n_ifmap_num = 5'(nif);
    for (int i = 0; i < n; i++) begin
      w_data  = 32'(base + i);
      w_valid = 1'b1;
      w_last  = (i == n - 1);
      g = 0;
      while (!w_ready && g < 50) begin
        step();
        g++;
      end
      if (g >= 50) chk("w_ready_timeout", 64'(w_ready), 64'(1));
      step();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic pulse(logic c, logic f, int nof);
    conv_en     = c;
    flush       = f;
    n_ofmap_num = 5'(nof);
    step();
    conv_en = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wait_drain(bit toggle);
    int g = 0;
    while ((drain_busy || sb.size() != 0) && g < 200) begin
      if (toggle) r_ready = ~r_ready;
      step();
      g++;
    end
    r_ready = 1'b1;
    chk("drain_done", 64'({drain_busy, sb.size() == 0}), 64'(1));
  endtask

  task automatic tread(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      tensor_addr = tv[i].addr;
      t_addr_vld  = 1'b1;
      step();
      chk("tensor_vld", 64'(tensor_vld), 64'(1));
      chk("tensor_data", 64'(tensor_data), 64'(tv[i].exp));
    end
    t_addr_vld = 1'b0;
    step();
    chk("tensor_vld_off", 64'(tensor_vld), 64'(0));
  endtask

  initial begin
    tv[0] = '{4'd5, 32'd5};
    tv[1] = '{4'd0, 32'd0};
    tv[2] = '{4'd15, 32'd15};
    tv[3] = '{4'd3, 32'd103};
    tv[4] = '{4'd7, 32'd107};
    tv[5] = '{4'd10, 32'd10};
    tv[6] = '{4'd0, 32'd616};
    tv[7] = '{4'd1, 32'd617};
    tv[8] = '{4'd2, 32'd602};

    rstn = 1'b0; enable = 1'b1; conv_en = 1'b0; flush = 1'b0;
    n_ifmap_num = '0; n_ofmap_num = '0;
    w_data = '0; w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b1;
    tensor_addr = '0; t_addr_vld = 1'b0;
    result_addr = '0; result_data = '0; result_w_vld = 1'b0;
    step();
    step();
    chk("rst_w_ready", 64'(w_ready), 64'(0));
    chk("rst_r_valid", 64'(r_valid), 64'(0));
    chk("rst_r_data", 64'(r_data), 64'(0));
    chk("rst_tensor", 64'({tensor_vld, tensor_data}), 64'(0));
    chk("rst_status", 64'({comp_bank, drain_busy, conv_err, len_err}), 64'(0));
    rstn = 1'b1;
    chk("w_ready_first", 64'(w_ready), 64'(0));
    step();
    chk("w_ready_up", 64'(w_ready), 64'(1));

    load(16, 0, 16);
    chk("w_ready_loaded", 64'(w_ready), 64'(0));
    pulse(1'b1, 1'b0, 0);
    chk("rot1_bank", 64'(comp_bank), 64'(1));
    chk("rot1_nodrain", 64'({drain_busy, conv_err}), 64'(0));
    chk("rot1_w_ready", 64'(w_ready), 64'(1));
    tread(0, 2);

    for (int i = 0; i < 8; i++) begin
      result_addr  = 4'(i);
      result_data  = 32'(100 + i);
      result_w_vld = 1'b1;
      step();
    end
    result_w_vld = 1'b0;
    tread(3, 5);

    pulse(1'b1, 1'b0, 8);
    chk("rej_unloaded_err", 64'(conv_err), 64'(1));
    chk("rej_unloaded_bank", 64'(comp_bank), 64'(1));
    step();
    chk("conv_err_pulse", 64'(conv_err), 64'(0));

    load(16, 200, 16);
    enable = 1'b0;
    pulse(1'b1, 1'b0, 8);
    chk("rej_disabled_err", 64'(conv_err), 64'(1));
    chk("rej_disabled_bank", 64'(comp_bank), 64'(1));
    enable = 1'b1;

    push(100, 8);
    pulse(1'b1, 1'b0, 8);
    chk("rot2_bank", 64'(comp_bank), 64'(2));
    chk("rot2_busy", 64'(drain_busy), 64'(1));
    chk("rot2_rv0", 64'(r_valid), 64'(0));
    step();
    chk("rot2_rv1", 64'(r_valid), 64'(0));
    step();
    chk("rot2_rv2", 64'(r_valid), 64'(1));
    wait_drain(1'b0);

    for (int i = 0; i < 16; i++) begin
      result_addr  = 4'(i);
      result_data  = 32'(300 + i);
      result_w_vld = 1'b1;
      step();
    end
    result_w_vld = 1'b0;
    load(16, 400, 16);
    r_ready = 1'b0;
    push(300, 16);
    pulse(1'b1, 1'b0, 16);
    chk("rot3_bank", 64'(comp_bank), 64'(3));
    load(16, 500, 16);
    pulse(1'b1, 1'b0, 4);
    chk("rej_busy_err", 64'(conv_err), 64'(1));
    chk("rej_busy_bank", 64'(comp_bank), 64'(3));
    wait_drain(1'b1);

    push(400, 4);
    pulse(1'b1, 1'b0, 4);
    chk("rot4_bank", 64'(comp_bank), 64'(0));
    wait_drain(1'b0);

    push(500, 3);
    pulse(1'b0, 1'b1, 3);
    chk("flush_busy", 64'(drain_busy), 64'(1));
    chk("flush_bank", 64'(comp_bank), 64'(0));
    wait_drain(1'b0);
    pulse(1'b0, 1'b1, 3);
    chk("flush_invalid_err", 64'(conv_err), 64'(1));

    load(18, 600, 18);
    chk("wrap_loaded", 64'(w_ready), 64'(0));
    pulse(1'b1, 1'b1, 2);
    chk("both_err", 64'(conv_err), 64'(0));
    chk("both_bank", 64'(comp_bank), 64'(1));
    chk("both_busy", 64'(drain_busy), 64'(0));
    step();
    chk("both_busy_late", 64'(drain_busy), 64'(0));
    tread(6, 8);

    load(6, 700, 8);
    step();
    chk("len_err", 64'(len_err), 64'(LEN_EN));

    r_ready = 1'b0;
    pulse(1'b1, 1'b0, 5);
    chk("mid_bank", 64'(comp_bank), 64'(2));
    step();
    step();
    step();
    chk("mid_live", 64'({drain_busy, r_valid}), 64'(3));
    rstn = 1'b0;
    #1;
    chk("mid_rst_r", 64'({r_valid, r_last, r_data}), 64'(0));
    chk("mid_rst_status",
        64'({comp_bank, drain_busy, w_ready, len_err}), 64'(0));
    step();
    rstn = 1'b1;
    r_ready = 1'b1;
    step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
